coproc_sequencer: RTL
=====================

COPROC_SEQUENCER -- requirements
Module: coproc_sequencer

Interface
REQ-001 Parameter ELEMS, default 25: matrix elements per operand (5x5, 8-bit signed each).
REQ-002 Parameter CALC_WAIT, default 70: cycles cp_start is held before the result is sampled.
REQ-003 clk  in  1  single clock; all logic on the rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid and cmd_ready are both high.
REQ-007 cmd_op  in  3  coprocessor op code.
REQ-008 cmd_scalar  in  8  scalar operand.
REQ-009 cmd_src_base  in  7  first source memory address.
REQ-010 cmd_dst_base  in  7  first result memory address.
REQ-011 cmd_abort  in  1  abort the active command.
REQ-012 mem_addr  out  7  memory address.
REQ-013 mem_we  out  1  memory write enable.
REQ-014 mem_wdata  out  16  memory write data.
REQ-015 mem_rdata  in  16  memory read data; valid 1 cycle after its address is presented. Bits [7:0] hold A, bits [15:8] hold B.
REQ-016 cp_op  out  3  op code to the coprocessor; cp_scalar  out  8  scalar to the coprocessor.
REQ-017 cp_matrix_a  out  200  operand A; cp_matrix_b  out  200  operand B; element i occupies bits [8i+7:8i].
REQ-018 cp_start  out  1  coprocessor start.
REQ-019 cp_result  in  200  coprocessor result; cp_overflow  in  1  coprocessor overflow flag.
REQ-020 busy  out  1  high when not in IDLE.
REQ-021 done  out  1  one-cycle completion pulse.
REQ-022 status_overflow  out  1  sticky overflow flag for the last command.

Function
REQ-023 States SHALL be IDLE, READ, CALC, WRITE and DONE; each valid command SHALL run them in that order.
REQ-024 On acceptance, the block SHALL latch op, scalar, src_base and dst_base, clear status_overflow and enter READ on the next cycle.
REQ-025 READ SHALL last ELEMS+1 cycles: in READ cycle k (k=0..ELEMS-1) mem_addr = src_base+k mod 128 with mem_we=0. In cycle k+1, mem_rdata[7:0] and [15:8] SHALL be captured into element k of A and B.
REQ-026 CALC SHALL hold cp_start=1 for exactly CALC_WAIT cycles. cp_op and cp_scalar SHALL be stable from the READ entry until the return to IDLE.
REQ-027 On the last CALC cycle the block SHALL register cp_result and set status_overflow if cp_overflow=1; cp_start SHALL be 0 from WRITE onward.
REQ-028 WRITE SHALL last ELEMS cycles: in cycle i, mem_we=1, mem_addr = dst_base+i mod 128, mem_wdata = {8'h00, result element i}.
REQ-029 DONE SHALL last 1 cycle with done=1 and mem_we=0, then return to IDLE.
REQ-030 Latency from the acceptance edge to the done pulse SHALL be 1+(ELEMS+1)+CALC_WAIT+ELEMS cycles: 122 with the defaults.
REQ-031 Address arithmetic SHALL wrap modulo 128. Element data SHALL be passed through unmodified with no sign extension into memory.
REQ-032 cmd_abort=1 in READ, CALC, WRITE or DONE SHALL force IDLE on the next edge. In that case done SHALL stay 0, mem_we and cp_start SHALL go 0, and memory writes already issued SHALL be retained.
REQ-033 cmd_abort in IDLE SHALL be ignored. If cmd_abort and an accepted cmd_valid occur in the same IDLE cycle, the command SHALL start.
REQ-034 cmd_valid outside IDLE SHALL be ignored, with no queuing.
REQ-035 mem_we SHALL be 1 only in WRITE.

Reset
REQ-036 While reset=0 at a clock edge, the block SHALL enter IDLE with the following values: cmd_ready=1, busy=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0, cp_start=0, cp_op=0, cp_scalar=0, cp_matrix_a=0, cp_matrix_b=0, status_overflow=0, and the result register cleared.
REQ-037 Reset asserted mid-command SHALL override every state and abort, with no done pulse.

Verification
REQ-038 Memory preloaded with addr 0..24 = {8'h01, k+1}; command op=1, src=0, dst=32 -> cp_matrix_a byte k = k+1 and cp_matrix_b bytes = 1; cp_start high exactly 70 cycles; addr 32..56 written with {00, result byte}; done at cycle 122.
REQ-039 src=120 -> read addresses 120..127 then 0..16; dst=110 -> writes to 110..127 then 0..6.
REQ-040 cp_overflow=1 on the last CALC cycle -> status_overflow=1 after done and held until the next acceptance; cp_overflow=1 only in earlier CALC cycles -> status_overflow=0.
REQ-041 cmd_abort on WRITE cycle 10 -> exactly 10 writes issued, IDLE next cycle, done never asserted, cmd_ready=1.
REQ-042 reset=0 during CALC -> every output equals its REQ-036 value on the next edge; a new command afterwards completes normally.
REQ-043 cmd_valid pulsed during READ -> ignored, with exactly one done pulse for the original command.

Source files
------------

// File: rtl/coproc_sequencer_if.sv
// Bus bundle between the coprocessor sequencer, its host, its operand/result memory
// and the matrix coprocessor. The sequencer connects through the master modport.
interface coproc_sequencer_if #(
    parameter int ELEMS = 25
);
    // Command handshake: a command transfers on a rising edge where cmd_valid and
    // cmd_ready are both high; cmd_ready is high only while the sequencer is idle, and
    // a request made while busy is simply dropped (the host must hold or re-issue it).
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [2:0]           cmd_op;
    logic [7:0]           cmd_scalar;
    logic [6:0]           cmd_src_base;
    logic [6:0]           cmd_dst_base;
    logic                 cmd_abort;

    logic [6:0]           mem_addr;
    logic                 mem_we;
    logic [15:0]          mem_wdata;
    logic [15:0]          mem_rdata;

    logic [2:0]           cp_op;
    logic [7:0]           cp_scalar;
    logic [8*ELEMS-1:0]   cp_matrix_a;
    logic [8*ELEMS-1:0]   cp_matrix_b;
    logic                 cp_start;
    logic [8*ELEMS-1:0]   cp_result;
    logic                 cp_overflow;

    logic                 busy;
    logic                 done;
    logic                 status_overflow;

    modport master (
        input  cmd_valid, cmd_op, cmd_scalar, cmd_src_base, cmd_dst_base, cmd_abort,
        input  mem_rdata, cp_result, cp_overflow,
        output cmd_ready, mem_addr, mem_we, mem_wdata,
        output cp_op, cp_scalar, cp_matrix_a, cp_matrix_b, cp_start,
        output busy, done, status_overflow
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_scalar, cmd_src_base, cmd_dst_base, cmd_abort,
        output mem_rdata, cp_result, cp_overflow,
        input  cmd_ready, mem_addr, mem_we, mem_wdata,
        input  cp_op, cp_scalar, cp_matrix_a, cp_matrix_b, cp_start,
        input  busy, done, status_overflow
    );
endinterface

// File: rtl/coproc_sequencer.sv
// Sequencer that gathers two matrix operands from memory, runs the coprocessor for a
// fixed number of cycles and writes the result matrix back, with abort support.
module coproc_sequencer #(
    parameter int ELEMS     = 25,
    parameter int CALC_WAIT = 70
) (
    input  logic                clk,
    input  logic                reset,
    coproc_sequencer_if.master  bus,
    output logic [2:0]          dbg_state
);
    localparam int W       = 8 * ELEMS;
    localparam int CNT_MAX = (CALC_WAIT > ELEMS + 1) ? CALC_WAIT : ELEMS + 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(ELEMS);
    localparam logic [CNT_W-1:0] CALC_LAST  = CNT_W'(CALC_WAIT - 1);
    localparam logic [CNT_W-1:0] WRITE_LAST = CNT_W'(ELEMS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_CALC  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       op_q;
    logic [7:0]       scalar_q;
    logic [6:0]       src_q, dst_q;
    logic [W-1:0]     mat_a, mat_b, result_q;
    logic             ovf_q;
    logic             accept, capture, calc_last;

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        accept        = 1'b0;
        capture       = 1'b0;
        calc_last     = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.busy      = 1'b1;
        bus.done      = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.cp_start  = 1'b0;
        case (state)
            S_IDLE: begin
                bus.cmd_ready = 1'b1;
                bus.busy      = 1'b0;
                if (bus.cmd_valid) begin
                    accept  = 1'b1;
                    state_n = S_READ;
                    cnt_n   = '0;
                end
            end
            S_READ: begin
                // Read data lags its address by one cycle, so cycle k stores element k-1.
                bus.mem_addr = src_q + 7'(cnt);
                capture      = (cnt != '0);
                if (cnt == READ_LAST) begin
                    state_n = S_CALC;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_CALC: begin
                bus.cp_start = !bus.cmd_abort;
                calc_last    = (cnt == CALC_LAST);
                if (calc_last) begin
                    state_n = S_WRITE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_WRITE: begin
                // An abort in this cycle suppresses the write it would have issued.
                bus.mem_we    = !bus.cmd_abort;
                bus.mem_addr  = dst_q + 7'(cnt);
                bus.mem_wdata = {8'h00, result_q[8*int'(cnt) +: 8]};
                if (cnt == WRITE_LAST) begin
                    state_n = S_DONE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_DONE: begin
                bus.done = !bus.cmd_abort;
                state_n  = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        if (state != S_IDLE && bus.cmd_abort) begin
            state_n = S_IDLE;
            cnt_n   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            op_q     <= '0;
            scalar_q <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            mat_a    <= '0;
            mat_b    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                op_q     <= bus.cmd_op;
                scalar_q <= bus.cmd_scalar;
                src_q    <= bus.cmd_src_base;
                dst_q    <= bus.cmd_dst_base;
                ovf_q    <= 1'b0;
            end
            if (capture) begin
                mat_a[8*(int'(cnt)-1) +: 8] <= bus.mem_rdata[7:0];
                mat_b[8*(int'(cnt)-1) +: 8] <= bus.mem_rdata[15:8];
            end
            if (calc_last && !bus.cmd_abort) begin
                result_q <= bus.cp_result;
                if (bus.cp_overflow) ovf_q <= 1'b1;
            end
        end
    end

    assign bus.cp_op           = op_q;
    assign bus.cp_scalar       = scalar_q;
    assign bus.cp_matrix_a     = mat_a;
    assign bus.cp_matrix_b     = mat_b;
    assign bus.status_overflow = ovf_q;
    assign dbg_state           = state;
endmodule
